// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-256 key-schedule controller.
// Holds the round-key count, the RCON start value, round-key and index
// types, the controller state encoding, and the forward S-box with a
// SubWord helper.
package aes_pkg;

    localparam int         AES_NRK   = 15;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [127:0] round_key_t;
    typedef logic [3:0]   rk_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Forward S-box. Element 0 sits in the leftmost byte, so SBOX[x] is S(x).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One AES-256 key-expansion step (combinational).
// The 256-bit working register holds eight words, word 0 in bits [255:224].
// Even step: t = SubWord(RotWord(word7)) ^ {rcon,24'h0}, folded into words 0..3.
// Odd step:  t = SubWord(word3), folded into words 4..7.
// Ports:
//   in    - current working register
//   odd   - 1 selects the odd step
//   rcon  - round constant used by the even step
//   next  - working register after this step
//   out   - the four freshly produced words (the new round key)
module aes256_key_step
    import aes_pkg::*;
(
    input  logic [255:0] in,
    input  logic         odd,
    input  logic [7:0]   rcon,
    output logic [255:0] next,
    output round_key_t   out
);

    logic [31:0]  sel_word;
    logic [31:0]  sub;
    logic [31:0]  t;
    logic [127:0] base;
    logic [31:0]  n0, n1, n2, n3;

    always_comb begin
        // One SubWord instance serves both step kinds through this input mux.
        sel_word = odd ? in[159:128] : {in[23:0], in[31:24]};
        sub      = sub_word(sel_word);
        t        = odd ? sub : (sub ^ {rcon, 24'h000000});
        base     = odd ? in[127:0] : in[255:128];
        n0       = base[127:96] ^ t;
        n1       = base[95:64]  ^ n0;
        n2       = base[63:32]  ^ n1;
        n3       = base[31:0]   ^ n2;
        out      = {n0, n1, n2, n3};
        next     = odd ? {in[255:128], n0, n1, n2, n3}
                       : {n0, n1, n2, n3, in[127:0]};
    end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key-schedule controller.
// Accepts a 256-bit key, writes rk0/rk1 directly, then runs one shared
// expansion step for 13 cycles to fill rk2..rk14 of a 15x128 table that
// the round engine reads by index.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   key_valid, key_in    - key offer; key_in[255:128] is rk0
//   key_ready            - key can be taken this cycle
//   clear                - synchronous zeroize/abort, overrides everything
//   busy                 - expansion in progress
//   keys_valid           - table holds the full schedule of the last key
//   done                 - one-cycle pulse when the schedule completes
//   rd_idx, rd_key       - table read port; index 15 reads zero
//
// Handshake: a key is taken on a rising edge where key_valid and key_ready
// are both high. key_ready depends only on state, clear and rst_n, never on
// key_valid; key_valid while not ready is ignored without side effects.
module aes256_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter bit RD_REG = 1'b1,
    parameter int NRK    = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [255:0] key_in,
    output logic         key_ready,
    input  logic         clear,
    output logic         busy,
    output logic         keys_valid,
    output logic         done,
    input  rk_idx_t      rd_idx,
    output round_key_t   rd_key
);

    if (NRK != AES_NRK) begin : g_nrk_check
        $error("aes256_key_sched_ctrl: NRK must be 15");
    end

    state_t       state;
    state_t       state_nx;
    logic [3:0]   step;
    logic [7:0]   rcon;
    logic [255:0] work;
    round_key_t   tbl [AES_NRK];
    logic         kv_q;
    logic         done_q;
    logic         accept;
    logic         last_step;
    logic [255:0] step_next;
    round_key_t   step_out;
    round_key_t   rd_comb;

    assign key_ready  = (state == IDLE) & ~clear & rst_n;
    assign accept     = key_valid & key_ready;
    assign last_step  = (step == 4'd14);
    assign busy       = (state == GEN);
    assign keys_valid = kv_q;
    assign done       = done_q;

    aes256_key_step u_step (
        .in   (work),
        .odd  (step[0]),
        .rcon (rcon),
        .next (step_next),
        .out  (step_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; clear aborts from any state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)    state_nx = GEN;
            GEN:  if (last_step) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    // Datapath: working register, step counter, rcon, table, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            step   <= 4'd0;
            rcon   <= RCON_INIT;
            kv_q   <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < AES_NRK; i++) tbl[i] <= '0;
        end else if (clear) begin
            work   <= '0;
            step   <= 4'd0;
            rcon   <= RCON_INIT;
            kv_q   <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < AES_NRK; i++) tbl[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                tbl[0] <= key_in[255:128];
                tbl[1] <= key_in[127:0];
                work   <= key_in;
                step   <= 4'd2;
                rcon   <= RCON_INIT;
                kv_q   <= 1'b0;
            end else if (state == GEN) begin
                work      <= step_next;
                tbl[step] <= step_out;
                step      <= step + 4'd1;
                // rcon advances only after an even step has consumed it
                if (!step[0]) rcon <= {rcon[6:0], 1'b0};
                if (last_step) begin
                    step   <= 4'd0;
                    kv_q   <= 1'b1;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign rd_comb = (rd_idx == 4'hF) ? '0 : tbl[rd_idx];

    if (RD_REG) begin : g_rd_reg
        round_key_t rd_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (clear) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_comb;
            end
        end
        assign rd_key = rd_q;
    end else begin : g_rd_comb
        assign rd_key = rd_comb;
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
module tb_aes256_key_sched_ctrl;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // Clock/reset and stimulus signals
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [255:0] key_in = '0;
    logic         clear = 1'b0;
    logic [3:0]   rd_idx = '0;

    logic         key_ready, busy, keys_valid, done;
    logic [127:0] rd_key_r;
    logic         key_ready_c, busy_c, keys_valid_c, done_c;
    logic [127:0] rd_key_c;

    always #5 clk = ~clk;

    aes256_key_sched_ctrl #(.RD_REG(1'b1), .NRK(15)) u_dut_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .clear      (clear),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key_r)
    );

    aes256_key_sched_ctrl #(.RD_REG(1'b0), .NRK(15)) u_dut_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready_c),
        .clear      (clear),
        .busy       (busy_c),
        .keys_valid (keys_valid_c),
        .done       (done_c),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key_c)
    );

    // Scoreboard
    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Independent key-expansion model; S-box derived from GF(2^8) inverse + affine map
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] v);
        return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
    endfunction

    function automatic logic [127:0] model_rk(input logic [255:0] key, input int idx);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        if (idx > 14) return '0;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = m_sub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                tmp = m_sub(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    // Read vector tables: set 0 = C.3 key, 1 = A.3 key, 2 = all zero
    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [3][16];

    // Driver tasks (called at posedge + 1)
    task automatic read_check(input logic [3:0] idx, input logic [127:0] exp, input string nm);
        rd_idx = idx;
        exp_q.push_back(exp);
        #1;
        check({nm, " comb"}, rd_key_c, exp);
        @(posedge clk); #1;
        check({nm, " reg"}, rd_key_r, exp_q.pop_front());
    endtask

    task automatic sweep(input int set, input string tag);
        for (int i = 0; i < 16; i++)
            read_check(vecs[set][i].idx, vecs[set][i].exp, $sformatf("%s rk%0d", tag, i));
    endtask

    task automatic start(input logic [255:0] key);
        key_valid = 1'b1;
        key_in    = key;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic watch(input bit stop_at_done, input bit hold, input logic [255:0] hold_key,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output int ready_busy, output int kv_low);
        lat = -1; busy_cnt = 0; done_cnt = 0; ready_busy = 0; kv_low = 0;
        if (hold) begin
            key_valid = 1'b1;
            key_in    = hold_key;
        end
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_cnt++;
            if (busy && key_ready) ready_busy++;
            if (!keys_valid) kv_low++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
                key_valid = 1'b0;
            end
            if (stop_at_done && done) break;
        end
        key_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dc, rb, kvl, done_seen;

        build_sbox();
        for (int i = 0; i < 16; i++) begin
            vecs[0][i].idx = i[3:0]; vecs[0][i].exp = model_rk(KEY_C3, i);
            vecs[1][i].idx = i[3:0]; vecs[1][i].exp = model_rk(KEY_A3, i);
            vecs[2][i].idx = i[3:0]; vecs[2][i].exp = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_int("rst key_ready", int'(key_ready), 0);
        check_int("rst busy", int'(busy), 0);
        check_int("rst keys_valid", int'(keys_valid), 0);
        check_int("rst done", int'(done), 0);
        check("rst rd_key", rd_key_r, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("idle key_ready", int'(key_ready), 1);
        sweep(2, "rst");

        // FIPS-197 C.3 key
        start(KEY_C3);
        watch(1'b0, 1'b0, '0, lat, bc, dc, rb, kvl);
        check_int("c3 latency", lat, 13);
        check_int("c3 done pulses", dc, 1);
        check_int("c3 busy cycles", bc, 13);
        check_int("c3 kv low cycles", kvl, 13);
        check_int("c3 keys_valid", int'(keys_valid), 1);
        read_check(4'd0, 128'h000102030405060708090a0b0c0d0e0f, "c3 const rk0");
        read_check(4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "c3 const rk2");
        read_check(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "c3 const rk14");
        sweep(0, "c3");

        // key_valid held with another key throughout GEN
        start(KEY_A3);
        watch(1'b0, 1'b1, KEY_C3, lat, bc, dc, rb, kvl);
        check_int("hold latency", lat, 13);
        check_int("hold busy cycles", bc, 13);
        check_int("hold ready in busy", rb, 0);
        check_int("hold done pulses", dc, 1);
        sweep(1, "hold");

        // Back-to-back: C.3 then A.3 right after done
        start(KEY_C3);
        watch(1'b1, 1'b0, '0, lat, bc, dc, rb, kvl);
        check_int("b2b A latency", lat, 13);
        check_int("b2b ready at done", int'(key_ready), 1);
        start(KEY_A3);
        watch(1'b0, 1'b0, '0, lat, bc, dc, rb, kvl);
        check_int("b2b B latency", lat, 13);
        check_int("b2b B kv low cycles", kvl, 13);
        read_check(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "a3 const rk14");
        sweep(1, "b2b");

        // Asynchronous reset mid-GEN
        rd_idx = 4'd0;
        start(KEY_C3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre-rst rd_key", rd_key_r, 128'h000102030405060708090a0b0c0d0e0f);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("midrst busy", int'(busy), 0);
        check_int("midrst keys_valid", int'(keys_valid), 0);
        check_int("midrst done", int'(done), 0);
        check_int("midrst key_ready", int'(key_ready), 0);
        check("midrst rd_key reg", rd_key_r, '0);
        check("midrst rd_key comb", rd_key_c, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("post-rst key_ready", int'(key_ready), 1);
        check_int("post-rst busy", int'(busy), 0);

        // clear at E6 of GEN
        start(KEY_C3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_int("pre-clear busy", int'(busy), 1);
        clear = 1'b1;
        #1;
        check_int("clear key_ready", int'(key_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        check_int("clear busy", int'(busy), 0);
        check_int("clear keys_valid", int'(keys_valid), 0);
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check_int("clear no done", done_seen, 0);
        sweep(2, "clear");
        check_int("clear then ready", int'(key_ready), 1);
        start(KEY_A3);
        watch(1'b0, 1'b0, '0, lat, bc, dc, rb, kvl);
        check_int("post-clear latency", lat, 13);
        read_check(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "post-clear rk14");

        // clear in IDLE with a valid schedule
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_int("idle clear keys_valid", int'(keys_valid), 0);
        read_check(4'd14, '0, "idle clear rk14");

        check_int("scoreboard empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_key_sched_ctrl.md
Name: aes256_key_sched_ctrl

Overview:
Iterative AES-256 key-schedule controller. It accepts a 256-bit cipher key through a valid/ready handshake and sequences one shared expansion step over 13 cycles, producing round keys rk2..rk14. All 15 round keys go into an internal 15x128 table, and the cipher round engine reads that table by index. This replaces the fully unrolled 13-stage expansion with one reused step, trading latency for area.

Parameters:
RD_REG, 1, 1 = rd_key registered (1-cycle read latency); 0 = combinational read
NRK, 15, number of round keys; fixed at 15, any other value is a compile-time error

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  key_in is valid
key_in  input  256  cipher key; bits [255:128] are rk0
key_ready  output  1  controller can accept a key (IDLE and not clear)
clear  input  1  synchronous zeroize/abort
busy  output  1  generation in progress
keys_valid  output  1  table holds a complete schedule for the last accepted key
done  output  1  one-cycle pulse when the schedule completes
rd_idx  input  4  round-key index 0..14
rd_key  output  128  round key at rd_idx

Behaviour:
- Reset (async, rst_n low): state IDLE; step=0; rcon=8'h01; table all zero; key_ready=0 while rst_n is low, then 1 in IDLE; busy=0, keys_valid=0, done=0, rd_key=0.
- Accept: key_valid & key_ready at edge E0.
  - rk0 <= key_in[255:128]; rk1 <= key_in[127:0].
  - Working register W <= key_in; step <= 2; rcon <= 8'h01; keys_valid <= 0; state -> GEN.
- GEN, edges E1..E13: the step module computes next from W; W <= next; rk[step] <= out; step++.
  - Even step: SubWord(RotWord(W[31:0])) ^ {rcon,24'h0} is folded into words 0..3; after use, rcon <= rcon<<1 (01,02,04,08,10,20,40).
  - Odd step: SubWord(W[159:128]), no rotate, no rcon, folded into words 4..7.
  - Even/odd is selected by step[0]==0.
- At E13 (rk14 written): state -> IDLE; keys_valid <= 1; done <= 1 for exactly one cycle. Fixed latency is 13 cycles from acceptance to keys_valid high.
- busy = (state==GEN). key_ready = (state==IDLE) & ~clear.
  - key_valid during GEN is ignored (not accepted, no side effect).
  - Back-to-back operation: a new key may be accepted in the cycle after done.
- Re-key in IDLE with keys_valid=1: keys_valid drops at the acceptance edge. Old entries rk2..rk14 stay readable but stale until overwritten.
- clear (priority over accept and GEN): at the next edge the table is zeroed, W=0, state IDLE, keys_valid=0, done=0, rcon=01. An abort mid-GEN produces no done pulse.
- Reset mid-GEN: immediate return to the reset values above.
- Read:
  - rd_idx 0..14 returns the table entry; rd_idx 15 returns 128'h0.
  - RD_REG=1: rd_key is valid one cycle after rd_idx.
  - Reads are legal at any time. Only data read while keys_valid=1 is guaranteed coherent.
- No combinational path from key_valid to key_ready.

Decomposition:
- Shared package aes_pkg: AES_NRK=15, RCON start value 8'h01, the round-key typedef (128-bit), the round-key index typedef (4-bit), and the state enum {IDLE, GEN}.
- One sub-module, aes256_key_step: a combinational even/odd expansion step.
  - Inputs: in[255:0], odd, rcon[7:0]. Outputs: next[255:0], out[127:0].
  - It instantiates one SubWord (4 S-boxes), shared between the even and odd paths through an input mux.

Test Plan:
1. FIPS-197 C.3 key 000102…1e1f, accepted at E0 -> done pulses once, 13 cycles later; rd_idx=2 gives a573c29fa176c498a97fce93a572c09c; rd_idx=14 gives 24fc79ccbf0979e9371ac23c6d68de36; rd_idx=0 gives 000102…0e0f.
2. Assert key_valid with a different key throughout GEN -> key_ready=0, schedule equals the first key's expansion, busy stays high for exactly 13 cycles.
3. clear at E6 of GEN -> next cycle all rd_idx 0..15 read 0, keys_valid=0, no done pulse; a new key is then accepted normally.
4. rst_n low mid-GEN (asynchronous, between edges) -> busy, keys_valid, done and rd_key go to 0 immediately; after release, key_ready=1.
5. Back-to-back: key A, done, then key B accepted in the following cycle -> keys_valid low for 13 cycles, then the table matches B's golden model (FIPS-197 A.3 key 603deb10…0914dff4: rk14 = fe4890d1e6188d0b046df344706c631e).
6. RD_REG=0 and RD_REG=1 builds: sweep rd_idx 0..15 -> combinational vs one-cycle-delayed data; index 15 reads 0.
